bram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one external `bram_1r1w` instance between `NUM_REQ` requesters. The read port and the write port are arbitrated independently. Read data returns one cycle after grant, tagged with the requester index. It sits between the traversal/shading clients and a shared on-chip buffer, so a single block RAM can serve several pipelines without duplicating storage.

---
 rtl/bram_port_arbiter_pkg.sv | 19 +
 rtl/bram_port_arbiter_if.sv | 37 +++
 rtl/bram_port_arbiter_rr_arbiter.sv | 46 ++++
 rtl/bram_port_arbiter.sv | 86 ++++++++
 tb/tb_bram_port_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and helpers for the BRAM port arbiter.
// Optional read-during-write bypass is enabled by defining BRAM_ARB_BYPASS_EN.
package bram_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAX_REQ        = 32;

  // OR-reduce the set bit positions; exact for one-hot, 0 for all-zero.
  function automatic int unsigned onehot_to_index(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | i;
    return idx;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester and memory-side bus of the BRAM port arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 rd_req;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]                 rd_grant;
  logic [NUM_REQ-1:0]                 wr_req;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]                 wr_grant;
  logic                               rsp_valid;
  logic [ID_WIDTH-1:0]                rsp_id;
  logic [DATA_WIDTH-1:0]              rsp_data;
  logic [ADDR_WIDTH-1:0]              mem_rd_addr;
  logic                               mem_wr_en;
  logic [ADDR_WIDTH-1:0]              mem_wr_addr;
  logic [DATA_WIDTH-1:0]              mem_wr_data;
  logic [DATA_WIDTH-1:0]              mem_rd_data;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rd_data,
    output rd_grant, wr_grant, rsp_valid, rsp_id, rsp_data,
           mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rd_data,
    input  rd_grant, wr_grant, rsp_valid, rsp_id, rsp_data,
           mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping
// modulo NUM_REQ (any NUM_REQ >= 2), then moves ptr past the winner.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] gidx;
  logic                found;
  int                  idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign gidx = ID_WIDTH'(onehot_to_index(MAX_REQ'(grant)));

  // Explicit wrap keeps ptr in range when NUM_REQ is not a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (|grant)
      ptr <= (gidx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gidx + ID_WIDTH'(1);
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one bram_1r1w between NUM_REQ requesters with independent read and
// write round-robin arbiters. Define BRAM_ARB_BYPASS_EN for write-to-read bypass.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  bram_port_arbiter_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    rd_grant, wr_grant;
  logic [ADDR_WIDTH-1:0] rd_addr_mux, wr_addr_mux;
  logic [DATA_WIDTH-1:0] wr_data_mux;
  logic [ID_WIDTH-1:0]   rd_idx;
  logic                  rsp_valid_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk(clk), .reset(reset), .req(bus.rd_req), .grant(rd_grant)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk(clk), .reset(reset), .req(bus.wr_req), .grant(wr_grant)
  );

  // AND-OR muxes: grants are one-hot, so idle ports naturally drive 0.
  always_comb begin
    rd_addr_mux = '0;
    wr_addr_mux = '0;
    wr_data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_grant[i]) rd_addr_mux = rd_addr_mux | bus.rd_addr[i];
      if (wr_grant[i]) begin
        wr_addr_mux = wr_addr_mux | bus.wr_addr[i];
        wr_data_mux = wr_data_mux | bus.wr_data[i];
      end
    end
  end

  assign rd_idx = ID_WIDTH'(onehot_to_index(MAX_REQ'(rd_grant)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= |rd_grant;
      rsp_id_q    <= rd_idx;
    end
  end

`ifdef BRAM_ARB_BYPASS_EN
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  // Same-cycle read/write collision: memory returns old data, so forward the new.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q      <= (|rd_grant) && (|wr_grant) && (rd_addr_mux == wr_addr_mux);
      byp_data_q <= wr_data_mux;
    end
  end

  assign bus.rsp_data = byp_q ? byp_data_q : bus.mem_rd_data;
`else
  assign bus.rsp_data = bus.mem_rd_data;
`endif

  assign bus.rd_grant    = rd_grant;
  assign bus.wr_grant    = wr_grant;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.mem_rd_addr = rd_addr_mux;
  assign bus.mem_wr_en   = |wr_grant;
  assign bus.mem_wr_addr = wr_addr_mux;
  assign bus.mem_wr_data = wr_data_mux;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural bram_1r1w model;
// a second NUM_REQ=3 instance covers the non-power-of-two pointer wrap.
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  bram_port_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus3 ();

  bram_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  bram_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );

  // Memory model: registered read returning old data on a same-cycle write.
  logic [31:0] mem [256];
  function automatic logic [31:0] init_val(input int a);
    return (a == 'h30) ? 32'h1111_1111 : 32'hC0DE_0000 + 32'(a);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    end
    bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];
  rsp_t e;

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
      end
    end
  end

  // Drive one cycle of requests just after the edge, check grants mid-cycle.
  task automatic step(input string nm, input logic [3:0] rq, input logic [3:0] wq,
                      input int erd, input int ewr, input logic [3:0][7:0] ra,
                      input logic [7:0] wa, input logic [31:0] wd, input logic [31:0] edata);
    @(posedge clk); #1;
    bus.rd_req  = rq;
    bus.wr_req  = wq;
    bus.rd_addr = ra;
    bus.wr_addr = {4{wa}};
    bus.wr_data = {4{wd}};
    #3;
    chk({nm, "_rd_grant"}, 64'(bus.rd_grant), (erd < 0) ? 64'd0 : (64'd1 << erd));
    chk({nm, "_wr_grant"}, 64'(bus.wr_grant), (ewr < 0) ? 64'd0 : (64'd1 << ewr));
    chk({nm, "_wr_en"}, 64'(bus.mem_wr_en), (ewr < 0) ? 64'd0 : 64'd1);
    if (erd >= 0) begin
      chk({nm, "_rd_addr"}, 64'(bus.mem_rd_addr), 64'(ra[erd]));
      sb.push_back('{erd, edata});
    end
    if (ewr >= 0) begin
      chk({nm, "_wr_addr"}, 64'(bus.mem_wr_addr), 64'(wa));
      chk({nm, "_wr_data"}, 64'(bus.mem_wr_data), 64'(wd));
    end
  endtask

  localparam logic [3:0][7:0] RA = {8'h43, 8'h42, 8'h41, 8'h40};

  initial begin
    int g;
    logic [31:0] col_exp;
`ifdef BRAM_ARB_BYPASS_EN
    col_exp = 32'h2222_2222;
`else
    col_exp = 32'h1111_1111;
`endif
    reset = 1'b1;
    bus.rd_req = '1; bus.wr_req = '1;
    bus.rd_addr = RA; bus.wr_addr = '0; bus.wr_data = '0;
    bus3.rd_req = '0; bus3.rd_addr = '0; bus3.wr_req = '0;
    bus3.wr_addr = '0; bus3.wr_data = '0; bus3.mem_rd_data = '0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_rd_grant", 64'(bus.rd_grant), 64'd0);
    chk("rst_wr_grant", 64'(bus.wr_grant), 64'd0);
    chk("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rd_addr", 64'(bus.mem_rd_addr), 64'd0);

    @(posedge clk); #1;
    reset = 1'b0;
    bus.rd_req = '0; bus.wr_req = '0;
    #3;
    chk("idle_rd_grant", 64'(bus.rd_grant), 64'd0);
    chk("idle_wr_addr", 64'(bus.mem_wr_addr), 64'd0);
    chk("idle_wr_data", 64'(bus.mem_wr_data), 64'd0);

    // Full rotation with all read requests held.
    for (int k = 0; k < 8; k++) begin
      g = k % 4;
      step("rot", 4'b1111, 4'b0000, g, -1, RA, 8'h0, 32'h0, 32'hC0DE_0040 + 32'(g));
    end

    step("skip1", 4'b0010, 4'b0000, 1, -1, RA, 8'h0, 32'h0, 32'hC0DE_0041);
    step("skip3", 4'b1001, 4'b0000, 3, -1, RA, 8'h0, 32'h0, 32'hC0DE_0043);
    step("skip0", 4'b1001, 4'b0000, 0, -1, RA, 8'h0, 32'h0, 32'hC0DE_0040);

    step("conc", 4'b0100, 4'b0010, 2, 1, {4{8'h20}}, 8'h10, 32'hA5A5_A5A5, 32'hC0DE_0020);
    step("col", 4'b0001, 4'b1000, 0, 3, {4{8'h30}}, 8'h30, 32'h2222_2222, col_exp);
    step("rb10", 4'b0001, 4'b0000, 0, -1, {4{8'h10}}, 8'h0, 32'h0, 32'hA5A5_A5A5);
    step("rb30", 4'b0001, 4'b0000, 0, -1, {4{8'h30}}, 8'h0, 32'h0, 32'h2222_2222);
    step("idle", 4'b0000, 4'b0000, -1, -1, RA, 8'h0, 32'h0, 32'h0);
    chk("idle2_wr_addr", 64'(bus.mem_wr_addr), 64'd0);

    // NUM_REQ=3: grant 2 wraps ptr to 0.
    @(posedge clk); #1; bus3.rd_req = 3'b100; #3;
    chk("n3_g2", 64'(bus3.rd_grant), 64'b100);
    @(posedge clk); #1; bus3.rd_req = 3'b101; #3;
    chk("n3_wrap0", 64'(bus3.rd_grant), 64'b001);
    @(posedge clk); #1; #3;
    chk("n3_g2b", 64'(bus3.rd_grant), 64'b100);
    @(posedge clk); #1; #3;
    chk("n3_wrap0b", 64'(bus3.rd_grant), 64'b001);
    @(posedge clk); #1; bus3.rd_req = '0;

    // Reset the cycle after a read grant: the response is dropped.
    step("mf", 4'b0100, 4'b0000, 2, -1, RA, 8'h0, 32'h0, 32'hC0DE_0042);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.rd_req = '0;
    sb.delete();
    #3;
    chk("mf_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mf_rsp_id", 64'(bus.rsp_id), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step("post", 4'b1010, 4'b0000, 1, -1, RA, 8'h0, 32'h0, 32'hC0DE_0041);
    step("end", 4'b0000, 4'b0000, -1, -1, RA, 8'h0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
